// File: rtl/fmul_pipe_if.sv
// Handshake bundle for fmul_pipe: operation request side and result side.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer, in_ready back to the producer.
interface fmul_pipe_if #(
  parameter int F_EXP  = 8,
  parameter int F_FLAC = 23,
  parameter int TAG_W  = 5
);
  localparam int F_WIDTH = 1 + F_EXP + F_FLAC;

  logic               in_valid;
  logic               in_ready;
  logic [F_WIDTH-1:0] in1;
  logic [F_WIDTH-1:0] in2;
  logic [2:0]         rm;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [F_WIDTH-1:0] out;
  logic [TAG_W-1:0]   out_tag;
  logic [4:0]         fflags;

  // Producer/consumer side.
  modport master (
    output in_valid, in1, in2, rm, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, fflags
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in1, in2, rm, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, fflags
  );
endinterface

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 multiplier: capture -> unpack/multiply -> normalise -> round/pack.
// Latency: result on out_valid 3 cycles after the accept edge, one op per cycle.
// Backpressure: global stall while out_valid & ~out_ready; in_ready = ~stall.
module fmul_pipe #(
  parameter int F_EXP  = 8,
  parameter int F_FLAC = 23,
  parameter int TAG_W  = 5
) (
  input  logic       CLK,
  input  logic       RST,
  fmul_pipe_if.slave io
);
  localparam int E   = F_EXP;
  localparam int M   = F_FLAC;
  localparam int W   = 1 + E + M;
  localparam int P   = 2 * M + 2;   // raw significand product width
  localparam int N   = P - 1;       // product after leading-one alignment
  localparam int SW  = N + M + 3;   // alignment value plus room for denormalising
  localparam int LZW = $clog2(M + 2);

  localparam logic [E+1:0] BIAS    = (E+2)'((1 << (E - 1)) - 1);
  localparam logic [E:0]   EXP_OVF = (E+1)'((1 << E) - 1);
  localparam logic [W-2:0] MAG_INF = {{E{1'b1}}, {M{1'b0}}};
  localparam logic [W-2:0] MAG_MAX = {{(E-1){1'b1}}, 1'b0, {M{1'b1}}};
  localparam logic [W-1:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             inf;
    logic             nan;
    logic             snan;
    logic [M:0]       sig;   // leading one at the MSB for any nonzero finite
    logic [E+1:0]     exp;   // signed, unbiased by nothing (effective exponent)
  } opnd_t;

  typedef struct packed {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef struct packed {
    logic             sign;
    logic [E+1:0]     exp;   // signed sum minus bias
    logic [P-1:0]     prod;
    logic             spec;
    logic             spec_nv;
    logic [W-1:0]     spec_res;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } mul_t;

  typedef struct packed {
    logic             sign;
    logic [E:0]       exp;   // biased field; 0 when the value is subnormal
    logic [M-1:0]     frac;
    logic             g;
    logic             r;
    logic             s;
    logic             tiny;
    logic             spec;
    logic             spec_nv;
    logic [W-1:0]     spec_res;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } nrm_t;

  // Leading-zero count of a significand; only called meaningfully on nonzero values.
  function automatic logic [LZW-1:0] lzc(input logic [M:0] v);
    logic [LZW-1:0] n;
    n = LZW'(M + 1);
    for (int i = 0; i <= M; i++) begin
      if (v[i]) n = LZW'(M - i);
    end
    return n;
  endfunction

  // Classify an operand and produce a left-justified significand with its exponent.
  function automatic opnd_t unpack(input logic [W-1:0] x);
    opnd_t          o;
    logic [E-1:0]   ex;
    logic [M-1:0]   fr;
    logic           ez;
    logic           emax;
    logic           fnz;
    logic [M:0]     raw;
    logic [LZW-1:0] lz;
    ex     = x[W-2:M];
    fr     = x[M-1:0];
    ez     = ~|ex;
    emax   = &ex;
    fnz    = |fr;
    o.sign = x[W-1];
    o.zero = ez & ~fnz;
    o.inf  = emax & ~fnz;
    o.nan  = emax & fnz;
    o.snan = emax & fnz & ~fr[M-1];
    raw    = {~ez, fr};
    lz     = lzc(raw);
    if (ez) begin
      o.sig = raw << lz;
      o.exp = (E+2)'(1) - (E+2)'(lz);
    end else begin
      o.sig = raw;
      o.exp = (E+2)'(ex);
    end
    return o;
  endfunction

  logic stall;
  logic adv;

  op_t  op_d,  op_q;
  mul_t mul_d, mul_q;
  nrm_t nrm_d, nrm_q;
  logic op_vld_q, mul_vld_q, nrm_vld_q, out_vld_q;

  logic [W-1:0]     res_d, out_q;
  logic [4:0]       flags_d, fflags_q;
  logic [TAG_W-1:0] out_tag_q;

  opnd_t ua, ub;

  logic            hi;
  logic [N-1:0]    norm;
  logic            st0;
  logic [E+1:0]    exp2;
  logic [E+1:0]    sh;
  logic [SW-2:0]   wide;
  logic [N-2:0]    shf;
  logic            lost;
  logic            tiny;

  logic            grs;
  logic            inc;
  logic [E+M:0]    rnd;
  logic [E:0]      rexp;
  logic            ovf;
  logic [W-2:0]    ovf_mag;

  // A full output that the consumer refuses freezes every stage at once.
  assign stall       = out_vld_q & ~io.out_ready;
  assign adv         = ~stall;
  assign io.in_ready = adv;

  assign io.out_valid = out_vld_q;
  assign io.out       = out_q;
  assign io.out_tag   = out_tag_q;
  assign io.fflags    = fflags_q;

  // Capture the incoming operation as presented.
  always_comb begin
    op_d     = '0;
    op_d.a   = io.in1;
    op_d.b   = io.in2;
    op_d.rm  = io.rm;
    op_d.tag = io.in_tag;
  end

  // Unpack both operands, multiply significands, add exponents, resolve specials.
  always_comb begin
    ua            = unpack(op_q.a);
    ub            = unpack(op_q.b);
    mul_d         = '0;
    mul_d.sign    = ua.sign ^ ub.sign;
    mul_d.exp     = ua.exp + ub.exp - BIAS;
    mul_d.prod    = P'(ua.sig) * P'(ub.sig);
    mul_d.rm      = (op_q.rm > RM_RMM) ? RM_RNE : op_q.rm;
    mul_d.tag     = op_q.tag;
    mul_d.spec    = ua.nan | ub.nan | ua.inf | ub.inf | ua.zero | ub.zero;
    mul_d.spec_nv = 1'b0;
    if (ua.nan | ub.nan) begin
      mul_d.spec_res = QNAN;
      mul_d.spec_nv  = ua.snan | ub.snan;
    end else if ((ua.zero & ub.inf) | (ua.inf & ub.zero)) begin
      mul_d.spec_res = QNAN;
      mul_d.spec_nv  = 1'b1;
    end else if (ua.inf | ub.inf) begin
      mul_d.spec_res = {mul_d.sign, MAG_INF};
    end else begin
      mul_d.spec_res = {mul_d.sign, {(W-1){1'b0}}};
    end
  end

  // Align the product's leading one, then denormalise if the exponent is below 1.
  always_comb begin
    hi   = mul_q.prod[P-1];
    norm = hi ? mul_q.prod[P-1:1] : mul_q.prod[P-2:0];
    st0  = hi & mul_q.prod[0];
    exp2 = mul_q.exp + (E+2)'(hi);
    tiny = exp2[E+1] | (exp2 == '0);
    sh   = (E+2)'(1) - exp2;
    wide = (SW-1)'({norm, {(M+3){1'b0}}} >> sh);
    nrm_d = '0;
    if (!tiny) begin
      shf       = norm[N-2:0];
      lost      = 1'b0;
      nrm_d.exp = exp2[E:0];
    end else if (sh >= (E+2)'(M + 3)) begin
      // Shifted past guard and round: only a sticky bit survives.
      shf       = '0;
      lost      = |norm;
      nrm_d.exp = '0;
    end else begin
      shf       = wide[SW-2:M+3];
      lost      = |wide[M+2:0];
      nrm_d.exp = '0;
    end
    nrm_d.sign     = mul_q.sign;
    nrm_d.frac     = shf[N-2:M];
    nrm_d.g        = shf[M-1];
    nrm_d.r        = shf[M-2];
    nrm_d.s        = (|shf[M-3:0]) | st0 | lost;
    nrm_d.tiny     = tiny;
    nrm_d.spec     = mul_q.spec;
    nrm_d.spec_nv  = mul_q.spec_nv;
    nrm_d.spec_res = mul_q.spec_res;
    nrm_d.rm       = mul_q.rm;
    nrm_d.tag      = mul_q.tag;
  end

  // Round, pack and flag; the frac carry ripples into the exponent field naturally.
  always_comb begin
    grs = nrm_q.g | nrm_q.r | nrm_q.s;
    unique case (nrm_q.rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = nrm_q.sign & grs;
      RM_RUP:  inc = ~nrm_q.sign & grs;
      RM_RMM:  inc = nrm_q.g;
      default: inc = nrm_q.g & (nrm_q.r | nrm_q.s | nrm_q.frac[0]);
    endcase
    rnd  = {nrm_q.exp, nrm_q.frac} + (E+M+1)'(inc);
    rexp = rnd[E+M:M];
    ovf  = rexp >= EXP_OVF;
    unique case (nrm_q.rm)
      RM_RTZ:  ovf_mag = MAG_MAX;
      RM_RDN:  ovf_mag = nrm_q.sign ? MAG_INF : MAG_MAX;
      RM_RUP:  ovf_mag = nrm_q.sign ? MAG_MAX : MAG_INF;
      default: ovf_mag = MAG_INF;
    endcase
    if (nrm_q.spec) begin
      res_d   = nrm_q.spec_res;
      flags_d = {nrm_q.spec_nv, 4'b0000};
    end else begin
      res_d   = ovf ? {nrm_q.sign, ovf_mag} : {nrm_q.sign, rnd[E+M-1:0]};
      flags_d = {1'b0, 1'b0, ovf, nrm_q.tiny & (grs | ovf), grs | ovf};
    end
  end

  // Operand capture register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_vld_q <= 1'b0;
      op_q     <= '0;
    end else if (adv) begin
      op_vld_q <= io.in_valid;
      op_q     <= op_d;
    end
  end

  // Product/exponent register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_vld_q <= 1'b0;
      mul_q     <= '0;
    end else if (adv) begin
      mul_vld_q <= op_vld_q;
      mul_q     <= mul_d;
    end
  end

  // Normalised significand register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      nrm_vld_q <= 1'b0;
      nrm_q     <= '0;
    end else if (adv) begin
      nrm_vld_q <= mul_vld_q;
      nrm_q     <= nrm_d;
    end
  end

  // Result register; holds steady while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      out_tag_q <= '0;
      fflags_q  <= '0;
    end else if (adv) begin
      out_vld_q <= nrm_vld_q;
      out_q     <= res_d;
      out_tag_q <= nrm_q.tag;
      fflags_q  <= flags_d;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe with a cycle model of the 3-cycle global-stall pipeline.
// Latency: results expected 3 cycles after each accept edge.
// Backpressure: out_ready patterns with a 4-cycle stall window plus random cycles.
module tb_fmul_pipe;
  localparam int NVEC = 26;

  logic clk;
  logic rst;

  fmul_pipe_if ifc ();

  fmul_pipe dut (
    .CLK (clk),
    .RST (rst),
    .io  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in1, in2, rm, expected product, expected fflags
  logic [31:0] v_a [NVEC] = '{
    32'h3FC00000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000, 32'h00800001,
    32'h00800001, 32'h00000000, 32'h7F800001, 32'h7FC00001, 32'h80000000, 32'h7F800000,
    32'h00000001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h00000001, 32'h00000001,
    32'h00FFFFFF, 32'hFF7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800001, 32'h7F800000,
    32'h7FC00000, 32'h80000000};
  logic [31:0] v_b [NVEC] = '{
    32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000,
    32'h3F000000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hC0000000,
    32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3E800000, 32'h3E800000,
    32'h3F000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h80000000,
    32'h7F800001, 32'hC0400000};
  logic [2:0] v_rm [NVEC] = '{
    3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd0, 3'd3, 3'd7, 3'd0, 3'd3, 3'd0, 3'd2, 3'd2, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0};
  logic [31:0] v_res [NVEC] = '{
    32'h40400000, 32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00400000, 32'h00400000,
    32'h00400001, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'hFF800000,
    32'h00000002, 32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h00000000, 32'h00000001,
    32'h00800000, 32'hFF800000, 32'h7F7FFFFF, 32'h7F800000, 32'h00400001, 32'h7FC00000,
    32'h7FC00000, 32'h00000000};
  logic [4:0] v_flg [NVEC] = '{
    5'h00, 5'h05, 5'h05, 5'h05, 5'h00, 5'h03, 5'h03, 5'h10, 5'h10, 5'h00, 5'h00, 5'h00,
    5'h00, 5'h01, 5'h01, 5'h01, 5'h03, 5'h03, 5'h03, 5'h05, 5'h05, 5'h05, 5'h03, 5'h10,
    5'h10, 5'h00};

  int n_chk;
  int n_fail;
  int n_deliv;

  // Expected occupancy of the four register stages and which vector each holds.
  bit [3:0] mv;
  int       mi [4];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // One clock: drive, check at negedge against the model, advance the model at posedge.
  task automatic cycle(input bit iv, input int idx, input bit ordy, input bit rs, output bit acc);
    bit stall;
    rst           = rs;
    ifc.in_valid  = iv;
    if (iv) begin
      ifc.in1    = v_a[idx];
      ifc.in2    = v_b[idx];
      ifc.rm     = v_rm[idx];
      ifc.in_tag = 5'(idx);
    end
    ifc.out_ready = ordy;
    @(negedge clk);
    stall = mv[3] && !ordy;
    chk_eq("in_ready", 32'(ifc.in_ready), 32'(!stall));
    chk_eq("out_valid", 32'(ifc.out_valid), 32'(mv[3]));
    if (mv[3]) begin
      chk_eq($sformatf("out[%0d]", mi[3]), ifc.out, v_res[mi[3]]);
      chk_eq($sformatf("fflags[%0d]", mi[3]), 32'(ifc.fflags), 32'(v_flg[mi[3]]));
      chk_eq($sformatf("out_tag[%0d]", mi[3]), 32'(ifc.out_tag), 32'(mi[3]));
    end
    if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) n_deliv++;
    @(posedge clk);
    acc = iv && !stall && !rs;
    if (rs) begin
      mv = '0;
    end else if (!stall) begin
      for (int k = 3; k > 0; k--) begin
        mv[k] = mv[k-1];
        mi[k] = mi[k-1];
      end
      mv[0] = acc;
      mi[0] = idx;
    end
    #1;
  endtask

  // Idle cycle that checks the output registers are cleared (model must be empty).
  task automatic chk_out_zero(input string pfx);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk_eq({pfx, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
    chk_eq({pfx, "_out"}, ifc.out, 32'd0);
    chk_eq({pfx, "_out_tag"}, 32'(ifc.out_tag), 32'd0);
    chk_eq({pfx, "_fflags"}, 32'(ifc.fflags), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int sent;
    bit ordy;
    n_chk         = 0;
    n_fail        = 0;
    n_deliv       = 0;
    mv            = '0;
    for (int k = 0; k < 4; k++) mi[k] = 0;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in1       = '0;
    ifc.in2       = '0;
    ifc.rm        = '0;
    ifc.in_tag    = '0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 0, 1'b1, 1'b1, acc);
    chk_out_zero("reset");

    // Every directed vector back to back with a free-running consumer.
    for (int i = 0; i < NVEC; i++) cycle(1'b1, i, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, 1'b0, acc);

    // Six ops under backpressure: cycles 4..7 hold out_ready low, then random.
    n_deliv = 0;
    sent    = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 4)       ordy = 1'b1;
      else if (c < 8)  ordy = 1'b0;
      else if (c < 24) ordy = 1'($urandom_range(0, 1));
      else             ordy = 1'b1;
      cycle(sent < 6, sent, ordy, 1'b0, acc);
      if (acc) sent++;
    end
    chk_eq("bp_sent", 32'(sent), 32'd6);
    chk_eq("bp_delivered", 32'(n_deliv), 32'd6);

    // Three ops in flight, then a one-cycle reset before any of them emerges.
    cycle(1'b1, 13, 1'b1, 1'b0, acc);
    cycle(1'b1, 14, 1'b1, 1'b0, acc);
    cycle(1'b1, 15, 1'b1, 1'b0, acc);
    n_deliv = 0;
    cycle(1'b0, 0, 1'b1, 1'b1, acc);
    chk_out_zero("midrst");
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b0, acc);
    cycle(1'b1, 0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, 1'b0, acc);
    chk_eq("midrst_delivered", 32'(n_deliv), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
